reset_request_gen: RTL and testbench

- Converts a raw, bouncing, active-low board push-button into a clean, fixed-length reset request pulse.
- The pulse feeds the reset input of the game reset chain.
- A request is issued only after the button is held continuously for HOLD_CYCLES. Shorter presses are reported as a 1-cycle short_press event for game logic.
- It is the initiator side of the reset chain: it produces requests, the chain consumes them.

---
 rtl/game_pkg.sv | 26 ++
 rtl/key_debounce.sv | 47 ++++
 rtl/reset_request_gen.sv | 159 +++++++++++++++
 tb/tb_reset_request_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the game board logic: FSM state encodings and default timing.
// RESET_REQ_LOCKOUT_EN adds the LOCKOUT state and its default window length.
package game_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int DEF_HOLD_CYCLES     = CLK_HZ * 2;   // 2 s
  localparam int DEF_PULSE_CYCLES    = 50;
  localparam int DEF_CNT_W           = 30;
`ifdef RESET_REQ_LOCKOUT_EN
  localparam int DEF_LOCKOUT_CYCLES  = CLK_HZ / 2;   // 500 ms
`endif

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_HOLD         = 3'd1;
  localparam logic [2:0] ST_PULSE        = 3'd2;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd3;
`ifdef RESET_REQ_LOCKOUT_EN
  localparam logic [2:0] ST_LOCKOUT      = 3'd4;
`endif

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer on an active-low button plus a stable-level filter.
// key_db is active-high (1 = pressed) and only toggles after a full stable run.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset_in,
  input  logic key_n,
  output logic key_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The run counter restarts whenever the synchronized level agrees with key_db.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d = ~db_q;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db = db_q;

endmodule

// File: rtl/reset_request_gen.sv
// Long-press push-button to fixed-length reset request, with short-press strobe.
// Define RESET_REQ_LOCKOUT_EN to add a post-release LOCKOUT window before re-arming.
module reset_request_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
`ifdef RESET_REQ_LOCKOUT_EN
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
`endif
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       key_n,
  output logic       req_out,
  output logic       short_press,
  output logic       holding,
  output logic [2:0] progress,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEG_LAST   = CNT_W'(HOLD_CYCLES / 8 - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
`ifdef RESET_REQ_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
`endif

  logic             key_db;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [2:0]       progress_q, progress_d;
  logic             short_q, short_d;
  logic             req_q, holding_q, busy_q;
`ifdef RESET_REQ_LOCKOUT_EN
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debounce (
    .clock   (clock),
    .reset_in(reset_in),
    .key_n   (key_n),
    .key_db  (key_db)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    seg_cnt_d   = seg_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    progress_d  = progress_q;
    short_d     = 1'b0;
`ifdef RESET_REQ_LOCKOUT_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d  = '0;
        seg_cnt_d   = '0;
        pulse_cnt_d = '0;
        progress_d  = 3'd0;
        if (key_db) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!key_db) begin
          state_d    = ST_IDLE;
          short_d    = 1'b1;
          hold_cnt_d = '0;
          seg_cnt_d  = '0;
          progress_d = 3'd0;
        end else begin
          if (seg_cnt_q == SEG_LAST) begin
            seg_cnt_d  = '0;
            progress_d = sat_inc3(progress_q);
          end else begin
            seg_cnt_d  = seg_cnt_q + CNT_W'(1);
          end
          if (hold_cnt_q == HOLD_LAST) begin
            state_d     = ST_PULSE;
            pulse_cnt_d = '0;
          end else begin
            hold_cnt_d  = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PULSE: begin
        // Release is deliberately ignored here so the pulse is never truncated.
        if (pulse_cnt_q == PULSE_LAST) state_d = ST_RELEASE_WAIT;
        else                           pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
      end
      ST_RELEASE_WAIT: begin
        if (!key_db) begin
`ifdef RESET_REQ_LOCKOUT_EN
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
`else
          state_d    = ST_IDLE;
          progress_d = 3'd0;
`endif
        end
      end
`ifdef RESET_REQ_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_IDLE;
          progress_d = 3'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      seg_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      progress_q  <= 3'd0;
      short_q     <= 1'b0;
      req_q       <= 1'b0;
      holding_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RESET_REQ_LOCKOUT_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      seg_cnt_q   <= seg_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      progress_q  <= progress_d;
      short_q     <= short_d;
      req_q       <= (state_d == ST_PULSE);
      holding_q   <= (state_d == ST_HOLD);
      busy_q      <= (state_d != ST_IDLE);
`ifdef RESET_REQ_LOCKOUT_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign req_out     = req_q;
  assign short_press = short_q;
  assign holding     = holding_q;
  assign progress    = progress_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Self-checking bench for reset_request_gen with small timing parameters and a
// cycle-level reference model built from the button/hold/pulse rules.
module tb_reset_request_gen;

  localparam int D   = 4;
  localparam int H   = 32;
  localparam int P   = 3;
  localparam int L   = 16;
  localparam int SEG = H / 8;

  localparam int M_IDLE = 0, M_HOLD = 1, M_PULSE = 2, M_RW = 3, M_LOCK = 4;

  logic       clock = 1'b0;
  logic       reset_in;
  logic       key_n;
  logic       req_out, short_press, holding, busy;
  logic [2:0] progress;
  logic [6:0] got;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model state
  bit m_s1, m_s2, m_db, m_short;
  int m_run, m_mode, m_el;

  always #5 clock = ~clock;

  assign got = {req_out, short_press, holding, progress, busy};

  reset_request_gen #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .PULSE_CYCLES   (P),
`ifdef RESET_REQ_LOCKOUT_EN
    .LOCKOUT_CYCLES (L),
`endif
    .CNT_W          (30)
  ) dut (
    .clock      (clock),
    .reset_in   (reset_in),
    .key_n      (key_n),
    .req_out    (req_out),
    .short_press(short_press),
    .holding    (holding),
    .progress   (progress),
    .busy       (busy)
  );

  // One clock of the reference: mode/elapsed-time view of the behaviour.
  task automatic model_step();
    bit db_old;
    if (reset_in) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
      m_mode = M_IDLE; m_el = 0; m_short = 0;
    end else begin
      db_old  = m_db;
      m_short = 0;
      case (m_mode)
        M_IDLE:  if (db_old) begin m_mode = M_HOLD; m_el = 0; end
        M_HOLD: begin
          if (!db_old) begin m_mode = M_IDLE; m_short = 1; end
          else if (m_el == H - 1) begin m_mode = M_PULSE; m_el = 0; end
          else m_el++;
        end
        M_PULSE: if (m_el == P - 1) m_mode = M_RW; else m_el++;
        M_RW: begin
          if (!db_old) begin
`ifdef RESET_REQ_LOCKOUT_EN
            m_mode = M_LOCK; m_el = 0;
`else
            m_mode = M_IDLE;
`endif
          end
        end
        M_LOCK:  if (m_el == L - 1) m_mode = M_IDLE; else m_el++;
        default: m_mode = M_IDLE;
      endcase
      if (m_s2 == m_db) m_run = 0;
      else if (m_run == D - 1) begin m_db = ~m_db; m_run = 0; end
      else m_run++;
      m_s2 = m_s1;
      m_s1 = ~key_n;
    end
  endtask

  function automatic logic [6:0] exp_out();
    logic [2:0] prog;
    if (m_mode == M_IDLE)      prog = 3'd0;
    else if (m_mode == M_HOLD) prog = (m_el / SEG > 7) ? 3'd7 : 3'(m_el / SEG);
    else                       prog = 3'd7;
    return {m_mode == M_PULSE, m_short, m_mode == M_HOLD, prog, m_mode != M_IDLE};
  endfunction

  task automatic step(input logic kn, input logic rst);
    key_n    = kn;
    reset_in = rst;
    @(posedge clock);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      tests_run++;
      if (got !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc %0d: got %b expected %b", cyc, got, 7'b0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
  endtask

  task automatic test_bounce();
    int busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step((i < 20) ? logic'((i / 2) % 2) : 1'b1, 1'b0);
      busy_seen += int'(busy);
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL bounce cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (busy_seen !== 0) begin
      tests_failed++;
      $display("FAIL bounce_busy: busy high for %0d cycles, expected 0", busy_seen);
    end
  endtask

  task automatic test_short_press();
    int shorts = 0, reqs = 0, max_prog = 0;
    for (int i = 0; i < 40; i++) begin
      step((i < 20) ? 1'b0 : 1'b1, 1'b0);
      shorts += int'(short_press);
      reqs   += int'(req_out);
      if (int'(progress) > max_prog) max_prog = int'(progress);
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL short_press cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (shorts !== 1 || reqs !== 0 || max_prog < 2) begin
      tests_failed++;
      $display("FAIL short_summary: shorts=%0d reqs=%0d max_prog=%0d, expected 1/0/>=2",
               shorts, reqs, max_prog);
    end
  endtask

  task automatic test_long_press();
    int reqs = 0, hold_rise = -1, first_req = -1;
    for (int i = 0; i < 80; i++) begin
      step((i < 60) ? 1'b0 : 1'b1, 1'b0);
      if (holding && hold_rise < 0) hold_rise = cyc;
      if (req_out && first_req < 0) first_req = cyc;
      reqs += int'(req_out);
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL long_press cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (reqs !== P || first_req - hold_rise !== H || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_summary: reqs=%0d latency=%0d busy=%b, expected %0d/%0d/0",
               reqs, first_req - hold_rise, busy, P, H);
    end
  endtask

  task automatic test_held_forever();
    int rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 230; i++) begin
      step((i < 200) ? 1'b0 : 1'b1, 1'b0);
      if (req_out && !prev) rises++;
      prev = req_out;
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL held_forever cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (rises !== 1) begin
      tests_failed++;
      $display("FAIL held_pulses: got %0d req pulses, expected 1", rises);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int waited = 0, since_rel = 0;
    while (!req_out && waited < 100) begin
      step(1'b0, 1'b0);
      waited++;
    end
    tests_run++;
    if (!req_out) begin
      tests_failed++;
      $display("FAIL mid_pulse_wait: req_out=%b after %0d cycles, expected 1", req_out, waited);
    end
    step(1'b0, 1'b0);               // second req_out cycle: reset is applied at the next edge
    step(1'b0, 1'b1);
    tests_run++;
    if (got !== 7'b0) begin
      tests_failed++;
      $display("FAIL mid_pulse_abort: got %b expected %b", got, 7'b0);
    end
    // key_db returns D+2 edges after release; the FSM enters HOLD one edge later.
    while (!holding && since_rel < 40) begin
      step(1'b0, 1'b0);
      since_rel++;
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL mid_pulse_rehold cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (since_rel !== D + 3) begin
      tests_failed++;
      $display("FAIL mid_pulse_latency: holding after %0d cycles, expected %0d", since_rel, D + 3);
    end
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
  endtask

`ifdef RESET_REQ_LOCKOUT_EN
  task automatic test_lockout();
    int lock_at = -1, hold_at = -1, bad_hold = 0;
    logic [2:0] prog_at_hold = 3'd7;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 50 && lock_at < 0; i++) begin
      step(1'b1, 1'b0);
      if (m_mode == M_LOCK) lock_at = cyc;
    end
    for (int i = 0; i < 80; i++) begin
      step((cyc - lock_at < 5) ? 1'b1 : 1'b0, 1'b0);
      if (cyc - lock_at < L && holding) bad_hold++;
      if (holding && hold_at < 0) begin hold_at = cyc; prog_at_hold = progress; end
      tests_run++;
      if (got !== exp_out()) begin
        tests_failed++;
        $display("FAIL lockout cyc %0d: got %b expected %b", cyc, got, exp_out());
      end
    end
    tests_run++;
    if (lock_at < 0 || bad_hold !== 0 || hold_at - lock_at !== L + 1 || prog_at_hold !== 3'd0) begin
      tests_failed++;
      $display("FAIL lockout_summary: bad_hold=%0d rehold_after=%0d prog=%0d, expected 0/%0d/0",
               bad_hold, hold_at - lock_at, prog_at_hold, L + 1);
    end
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic kn_q[$];
    int bl, pl, rl;
    for (int n = 0; n < 14; n++) begin
      kn_q.delete();
      bl = $urandom_range(0, 8);
      pl = $urandom_range(1, 90);
      rl = $urandom_range(8, 60);
      for (int i = 0; i < bl; i++) kn_q.push_back(logic'($urandom_range(0, 1)));
      for (int i = 0; i < pl; i++) kn_q.push_back(1'b0);
      for (int i = 0; i < rl; i++) kn_q.push_back(1'b1);
      foreach (kn_q[i]) begin
        step(kn_q[i], logic'($urandom_range(0, 199) == 0));
        tests_run++;
        if (got !== exp_out()) begin
          tests_failed++;
          $display("FAIL random iter %0d cyc %0d: got %b expected %b", n, cyc, got, exp_out());
        end
      end
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    key_n    = 1'b1;
    reset_in = 1'b1;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_held_forever();
    test_reset_mid_pulse();
`ifdef RESET_REQ_LOCKOUT_EN
    test_lockout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule
